// File: rtl/thermometer_ramp_encoder.sv
// Binary-to-thermometer encoder that slews one segment per clock toward each accepted level.
// Define THERM_INSTANT_EN to load the accepted level directly, with no ramp.
module thermometer_ramp_encoder #(
    parameter int K = 3,
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [K-1:0] in_code,
    output logic         in_ready,
    output logic [W-1:0] therm,
    output logic [K-1:0] level,
    output logic         busy,
    output logic         done
);

    localparam logic [K-1:0] W_MAX = K'(W);

    typedef enum logic [1:0] {
        IDLE,
        RAMP_UP,
        RAMP_DOWN
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [K-1:0] target;
    logic [K-1:0] target_next;
    logic [K-1:0] level_next;
    logic [K-1:0] code_clamped;
    logic         done_next;
    logic         accept;

    function automatic logic [W-1:0] to_therm(input logic [K-1:0] lvl);
        logic [W-1:0] t;
        t = '0;
        for (int i = 0; i < W; i++) begin
            t[i] = (i < int'(lvl));
        end
        return t;
    endfunction

    // Codes above W can only occur when W < 2^K-1; they saturate at full scale.
    assign code_clamped = (in_code > W_MAX) ? W_MAX : in_code;
    assign accept       = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
`ifdef THERM_INSTANT_EN
        state_next = IDLE;
`else
        case (state)
            IDLE: begin
                if (accept) begin
                    if (code_clamped > level) begin
                        state_next = RAMP_UP;
                    end else if (code_clamped < level) begin
                        state_next = RAMP_DOWN;
                    end
                end
            end
            RAMP_UP, RAMP_DOWN: begin
                if (level_next == target) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
`endif
    end

    always_comb begin
        busy     = (state != IDLE);
        in_ready = (state == IDLE);
    end

    // Level, target and done pulse for the next edge; saturating steps guard against wrap.
    always_comb begin
        level_next  = level;
        target_next = target;
        done_next   = 1'b0;
`ifdef THERM_INSTANT_EN
        if (accept) begin
            target_next = code_clamped;
            level_next  = code_clamped;
            done_next   = 1'b1;
        end
`else
        case (state)
            IDLE: begin
                if (accept) begin
                    target_next = code_clamped;
                    done_next   = (code_clamped == level);
                end
            end
            RAMP_UP: begin
                if (level != W_MAX) begin
                    level_next = level + K'(1);
                end
                done_next = (level_next == target);
            end
            RAMP_DOWN: begin
                if (level != '0) begin
                    level_next = level - K'(1);
                end
                done_next = (level_next == target);
            end
            default: begin
                level_next = level;
            end
        endcase
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level  <= '0;
            target <= '0;
            therm  <= '0;
            done   <= 1'b0;
        end else begin
            level  <= level_next;
            target <= target_next;
            therm  <= to_therm(level_next);
            done   <= done_next;
        end
    end

endmodule

// File: doc/thermometer_ramp_encoder.md
# thermometer_ramp_encoder

Sequential binary-to-thermometer encoder: accepts a K-bit level code over a valid/ready handshake and drives a W-bit thermometer output that steps one segment per clock toward the new level. It is the inverse of the team's thermometer decoder and sits in front of segmented DAC or LED-bar drivers, where slew-limited, glitch-free segment switching is required.

## Interface

Parameters:
- K, 3, width of the binary level code
- W, 7, thermometer width; must equal 2^K-1

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous reset, active-low
- in_valid  input  1  in_code is valid this cycle
- in_code  input  K  requested level, 0..W
- in_ready  output  1  block can accept a code (high only in IDLE)
- therm  output  W  thermometer code; therm[i] = (i < level)
- level  output  K  current binary level driving therm
- busy  output  1  ramp in progress (state != IDLE)
- done  output  1  one-cycle pulse when level reaches the accepted target

Decided: one clock; reset is asynchronous and active-low.

## Operation

- State machine: IDLE, RAMP_UP, RAMP_DOWN.
- Handshake: a transfer occurs on any rising edge where in_valid && in_ready. The target register latches in_code on that edge. in_valid while in_ready=0 is ignored; no queuing.
- Transitions on the accept edge from IDLE:
  - in_code > level: go to RAMP_UP.
  - in_code < level: go to RAMP_DOWN.
  - in_code == level: stay in IDLE and pulse done.
- RAMP_UP: level increments by 1 per edge. When the new level equals target, go to IDLE and pulse done.
- RAMP_DOWN: same as RAMP_UP, but level decrements by 1 per edge.
- therm is registered and derived from level. Exactly one therm bit changes per ramp step.
  - Up: the lowest zero bit sets.
  - Down: the highest one bit clears.
- Width rules:
  - level and target are K bits, range 0..W.
  - No wrap-around: level never steps below 0 or above W.
  - If W < 2^K-1 (a misconfiguration), in_code values above W are clamped to W at latch time.
- Outputs:
  - busy = (state != IDLE).
  - in_ready = (state == IDLE).
  - done is registered and high for exactly one cycle per accepted code.

## Timing

- Reset values (asynchronous, immediate on rst_n low, including mid-ramp):
  - State and registers: state=IDLE, level=0, target=0.
  - Outputs: therm=0, done=0, busy=0, in_ready=1.
- Latency: the accept happens at edge E0. For a distance d = |in_code - level| > 0:
  - level changes at edges E1..Ed.
  - After Ed: done=1 for one cycle, busy=0, in_ready=1.
  - The next accept can occur at edge Ed+1.
  - Total: d cycles from accept to final therm.
- For d = 0: done=1 for the cycle after E0, in_ready stays 1, and therm is unchanged. A new accept at E1 is legal and coincides with that done pulse.
- Full-scale ramp from 0 to W takes W cycles.
- Release of rst_n: first accept possible on the first rising edge with rst_n high.

## Configuration

- THERM_INSTANT_EN:
  - Defined: ramping is disabled. On the accept edge, level and therm load the target directly, done pulses the following cycle, busy stays 0, and in_ready stays 1. The RAMP states are not synthesized.
  - Undefined (default): slew-limited ramp of one step per cycle, as described above.

## Test plan

- Reset mid-ramp: start a 0→7 ramp, assert rst_n low after 3 steps → therm=0, level=0, in_ready=1 immediately, with no done pulse.
- Full-scale up: from reset, accept in_code=7 → therm goes 0000001, 0000011, …, 1111111 over 7 cycles; done pulses once after the 7th step; busy high for exactly 7 cycles.
- Down ramp: from level 7, accept in_code=2 → 5 steps, each clearing the top one bit; final therm=0000011; done after step 5.
- Equal code and back-to-back: at level 4, accept in_code=4 → therm unchanged and done pulses the next cycle. In that same cycle, accept in_code=6 → 2-step ramp, done after step 2.
- Ignored input: during a 0→7 ramp, hold in_valid=1 with in_code=1 → ignored until in_ready=1. It is accepted on the first IDLE edge, then level ramps 7→1 over 6 cycles.
- THERM_INSTANT_EN defined: accept in_code=5 from level 0 → therm=0011111 after one edge, done the next cycle, busy never high.
